// File: rtl/fifo_drain_qam64_ctrl_if.sv
// Handshake bundle between the byte FIFO read side, the controller and the QAM-64 mapper.
// The master side is the environment; the slave side is the drain controller.
interface fifo_drain_qam64_ctrl_if;
    logic        en;
    logic        flush_req;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd_en;
    logic        sym_valid;
    logic        sym_ready;
    logic [5:0]  sym_data;
    logic        sym_pad;
    logic [15:0] sym_count;
    logic        busy;

    modport master (
        output en, flush_req, fifo_empty, fifo_data, sym_ready,
        input  fifo_rd_en, sym_valid, sym_data, sym_pad, sym_count, busy
    );

    modport slave (
        input  en, flush_req, fifo_empty, fifo_data, sym_ready,
        output fifo_rd_en, sym_valid, sym_data, sym_pad, sym_count, busy
    );
endinterface

// File: rtl/fifo_drain_qam64_ctrl.sv
// Drains bytes from a CDC FIFO into 6-bit QAM-64 symbols, oldest bit first.
// Starved partial symbols are zero-padded and flushed after a timeout or on request.
module fifo_drain_qam64_ctrl #(
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input logic                    read_clk,
    input logic                    read_rst,
    fifo_drain_qam64_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StFill, StFlush} state_e;

    localparam logic [7:0] Timeout = 8'(IDLE_TIMEOUT);

    state_e      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic [7:0]  starve_q, starve_d;
    logic [15:0] sym_count_q, sym_count_d;

    logic        rd_en, sym_valid, xfer, flush_go, partial;
    logic [15:0] acc_pop;
    logic [4:0]  cnt_pop;

    always_comb begin
        rd_en     = !read_rst && bus.en && !bus.fifo_empty && !pending_q &&
                    (cnt_q <= 5'd7) && (state_q != StFlush);
        sym_valid = !read_rst && ((cnt_q >= 5'd6) || (state_q == StFlush));
        xfer      = sym_valid && bus.sym_ready;
        partial   = (cnt_q >= 5'd1) && (cnt_q <= 5'd5) && !pending_q;
        // A read issued this cycle refills the partial symbol, so it wins over flushing.
        flush_go  = (state_q == StFill) && partial && !rd_en &&
                    ((starve_q == Timeout) || bus.flush_req);

        acc_pop = acc_q;
        cnt_pop = cnt_q;
        if (xfer) begin
            if (state_q == StFlush) begin
                acc_pop = '0;
                cnt_pop = '0;
            end else begin
                acc_pop = acc_q << 6;
                cnt_pop = cnt_q - 5'd6;
            end
        end

        // Bits below cnt are kept zero, so the returning byte can simply be OR-ed in.
        acc_d = acc_pop;
        cnt_d = cnt_pop;
        if (pending_q) begin
            acc_d = acc_pop | ({bus.fifo_data, 8'h00} >> cnt_pop);
            cnt_d = cnt_pop + 5'd8;
        end
        pending_d = rd_en;

        state_d = state_q;
        if (state_q == StFlush) begin
            if (xfer) state_d = StIdle;
        end else if (flush_go) begin
            state_d = StFlush;
        end else if ((cnt_d != 5'd0) || pending_d) begin
            state_d = StFill;
        end else begin
            state_d = StIdle;
        end

        sym_count_d = sym_count_q + (xfer ? 16'd1 : 16'd0);

        starve_d = starve_q;
        if (rd_en || xfer || (state_d != state_q)) begin
            starve_d = '0;
        end else if ((state_q == StFill) && partial && bus.fifo_empty &&
                     (starve_q != Timeout)) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge read_clk) begin
        if (read_rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            starve_q    <= '0;
            sym_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            starve_q    <= starve_d;
            sym_count_q <= sym_count_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.sym_valid  = sym_valid;
    assign bus.sym_data   = read_rst ? 6'd0 : acc_q[15:10];
    assign bus.sym_pad    = !read_rst && (state_q == StFlush);
    assign bus.sym_count  = sym_count_q;
    assign bus.busy       = !read_rst && ((state_q != StIdle) || pending_q);
endmodule

// File: tb/tb_fifo_drain_qam64_ctrl.sv
// Bench for fifo_drain_qam64_ctrl: bit-queue reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_drain_qam64_ctrl;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_drain_qam64_ctrl_if bus ();
    fifo_drain_qam64_ctrl #(.IDLE_TIMEOUT(T)) dut (.read_clk(clk), .read_rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Environment
    logic [7:0] src[$];
    logic       stall;
    logic [7:0] ret_byte;

    // Reference model: bit queue, oldest bit first
    bit          mq[$];
    bit          mpend;
    bit          mflush;
    int          mstarve;
    logic [15:0] mcount;

    // Logged accepted symbols
    logic [5:0] got[$];
    bit         gotpad[$];
    int         gotcyc[$];
    int         cyc;
    bit         last_rd;
    int         last_sz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int label();
        if (mflush) return 2;
        if (mq.size() > 0 || mpend) return 1;
        return 0;
    endfunction

    function automatic logic [5:0] head6();
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) if (i < mq.size()) r[5-i] = mq[i];
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        mpend = 0;
        mflush = 0;
        mstarve = 0;
        mcount = '0;
    endtask

    // One clock: compare at the falling edge, advance the model, re-drive after the rising edge.
    task automatic step();
        bit e_rd, e_val, e_busy, e_pad, xfer, go, pend0;
        logic [5:0] e_data;
        int sz0, lbl0;
        bus.fifo_empty = (src.size() == 0) || stall;
        @(negedge clk);
        sz0    = mq.size();
        pend0  = mpend;
        e_rd   = !rst && bus.en && !bus.fifo_empty && !mpend && sz0 <= 7 && !mflush;
        e_val  = !rst && (sz0 >= 6 || mflush);
        e_busy = !rst && (sz0 > 0 || mpend);
        e_data = head6();
        e_pad  = mflush;
        chk("fifo_rd_en", bus.fifo_rd_en, e_rd);
        chk("sym_valid", bus.sym_valid, e_val);
        chk("busy", bus.busy, e_busy);
        if (!rst) chk("sym_count", bus.sym_count, mcount);
        if (e_val) begin
            chk("sym_data", bus.sym_data, e_data);
            chk("sym_pad", bus.sym_pad, e_pad);
        end
        xfer = e_val && bus.sym_ready;
        if (xfer) begin
            got.push_back(bus.sym_data);
            gotpad.push_back(bus.sym_pad);
            gotcyc.push_back(cyc);
        end
        last_rd = e_rd;
        last_sz = sz0;
        if (rst) begin
            model_reset();
        end else begin
            lbl0 = label();
            go = !mflush && sz0 >= 1 && sz0 <= 5 && !mpend && !e_rd &&
                 (mstarve == T || bus.flush_req);
            if (xfer) begin
                if (mflush) begin
                    mq.delete();
                    mflush = 0;
                end else begin
                    repeat (6) void'(mq.pop_front());
                end
                mcount++;
            end
            if (mpend) for (int i = 7; i >= 0; i--) mq.push_back(ret_byte[i]);
            mpend = e_rd;
            if (go) mflush = 1;
            if (e_rd || xfer || lbl0 != label()) mstarve = 0;
            else if (lbl0 == 1 && sz0 >= 1 && sz0 <= 5 && !pend0 && bus.fifo_empty &&
                     mstarve < T) mstarve++;
        end
        if (e_rd) ret_byte = src.pop_front();
        @(posedge clk);
        #1;
        cyc++;
        bus.fifo_data = e_rd ? ret_byte : 8'($urandom);
        bus.flush_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src.delete();
        repeat (2) step();
        rst = 1'b0;
        got.delete();
        gotpad.delete();
        gotcyc.delete();
    endtask

    initial begin
        logic [7:0] bytes6[6];
        logic [47:0] want_bits, got_bits;
        int n;
        cyc = 0;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.flush_req = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data = '0;
        bus.sym_ready = 1'b0;
        stall = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        chk("rst_rd_en", bus.fifo_rd_en, 0);
        chk("rst_valid", bus.sym_valid, 0);
        chk("rst_data", bus.sym_data, 0);
        chk("rst_pad", bus.sym_pad, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_count", bus.sym_count, 0);

        // Three bytes, mapper always ready
        bus.en = 1'b1;
        bus.sym_ready = 1'b1;
        src = '{8'hFC, 8'h0F, 8'hC3};
        repeat (15) step();
        chk("seq_n", got.size(), 4);
        if (got.size() == 4) begin
            chk("seq_s0", got[0], 6'h3F);
            chk("seq_s1", got[1], 6'h00);
            chk("seq_s2", got[2], 6'h3F);
            chk("seq_s3", got[3], 6'h03);
            chk("seq_pad", {gotpad[0], gotpad[1], gotpad[2], gotpad[3]}, 0);
        end
        chk("seq_count", bus.sym_count, 4);
        chk("seq_idle", bus.busy, 0);

        // Single byte, timeout flush
        do_reset();
        src = '{8'hA5};
        repeat (30) step();
        chk("to_n", got.size(), 2);
        if (got.size() == 2) begin
            chk("to_s0", {gotpad[0], got[0]}, {1'b0, 6'h29});
            chk("to_s1", {gotpad[1], got[1]}, {1'b1, 6'h10});
        end
        chk("to_count", bus.sym_count, 2);

        // Single byte, explicit flush two cycles after the first symbol
        do_reset();
        src = '{8'hA5};
        n = 0;
        while (got.size() == 0 && n < 10) begin
            step();
            n++;
        end
        chk("fr_first", got.size(), 1);
        step();
        bus.flush_req = 1'b1;
        step();
        step();
        chk("fr_n", got.size(), 2);
        if (got.size() == 2) begin
            chk("fr_s1", {gotpad[1], got[1]}, {1'b1, 6'h10});
            chk("fr_gap", gotcyc[1] - gotcyc[0], 3);
        end

        // Back-pressure: six bytes with the mapper stalled for ten cycles
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bytes6[i] = 8'($urandom);
            src.push_back(bytes6[i]);
            want_bits = {want_bits[39:0], bytes6[i]};
        end
        bus.sym_ready = 1'b0;
        repeat (10) step();
        chk("bp_none", got.size(), 0);
        bus.sym_ready = 1'b1;
        repeat (30) step();
        chk("bp_n", got.size(), 8);
        if (got.size() == 8) begin
            for (int i = 0; i < 8; i++) got_bits = {got_bits[41:0], got[i]};
            chk("bp_bits_hi", got_bits[47:24], want_bits[47:24]);
            chk("bp_bits_lo", got_bits[23:0], want_bits[23:0]);
        end
        chk("bp_count", bus.sym_count, 8);

        // Empty FIFO with reads enabled
        do_reset();
        repeat (10) step();
        chk("empty_busy", bus.busy, 0);
        chk("empty_n", got.size(), 0);

        // Reset one cycle after a read issued with four bits held
        do_reset();
        src = '{8'hA5, 8'h3C, 8'h96};
        n = 0;
        last_rd = 0;
        while (!(last_rd && last_sz == 4) && n < 20) begin
            step();
            n++;
        end
        chk("mid_reached", {last_rd, 5'(last_sz)}, {1'b1, 5'd4});
        src.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.fifo_empty = 1'b1;
        #1;
        chk("mid_rd_en", bus.fifo_rd_en, 0);
        chk("mid_valid", bus.sym_valid, 0);
        chk("mid_data", bus.sym_data, 0);
        chk("mid_pad", bus.sym_pad, 0);
        chk("mid_busy", bus.busy, 0);
        chk("mid_count", bus.sym_count, 0);
        repeat (3) step();

        // Randomized traffic, with periodic long starvation windows
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            bus.en = ($urandom_range(0, 7) != 0);
            stall = ((c % 300) >= 250) ? 1'b1 : ($urandom_range(0, 3) == 0);
            bus.sym_ready = ($urandom_range(0, 2) != 0);
            bus.flush_req = ($urandom_range(0, 15) == 0);
            if (src.size() < 3 && $urandom_range(0, 1) == 1) src.push_back(8'($urandom));
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
